// File: rtl/arb_burst_ctrl_if.sv
// Client-side request channels plus the shared downstream beat channel of arb_burst_ctrl.
// slave is the controller's view; master is the view of whatever drives clients and sink.
interface arb_burst_ctrl_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4
);
  logic [NUM_PORTS-1:0]          req_valid;
  logic [NUM_PORTS*LEN_W-1:0]    req_len;
  logic [NUM_PORTS*DATA_W-1:0]   req_data;
  logic [NUM_PORTS-1:0]          req_ready;
  logic [NUM_PORTS-1:0]          done;
  logic                          out_valid;
  logic [DATA_W-1:0]             out_data;
  logic [$clog2(NUM_PORTS)-1:0]  out_id;
  logic                          out_last;
  logic                          out_ready;

  modport slave (
    input  req_valid, req_len, req_data, out_ready,
    output req_ready, done, out_valid, out_data, out_id, out_last
  );

  modport master (
    output req_valid, req_len, req_data, out_ready,
    input  req_ready, done, out_valid, out_data, out_id, out_last
  );
endinterface

// File: rtl/arb_burst_ctrl.sv
// Locks a single-cycle arbiter grant into a multi-beat burst on one shared valid/ready channel.
// Optional stall timeout with per-client timeout pulse when ARB_BURST_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | req_valid forwarded to arbiter, waiting for a grant to a valid client
// XFER  | owner locked; beats passed through until the last one is accepted
module arb_burst_ctrl #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  arb_burst_ctrl_if.slave              bus,
  output logic [NUM_PORTS-1:0]         arb_request,
  input  logic [$clog2(NUM_PORTS)-1:0] arb_grant_id,
  input  logic                         arb_valid_grant,
  output logic                         busy
`ifdef ARB_BURST_TIMEOUT_EN
  ,
  output logic [NUM_PORTS-1:0]         timeout
`endif
);

  localparam int ID_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic [NUM_PORTS-1:0] owner_oh;
  logic [LEN_W-1:0]     len_arr  [NUM_PORTS];
  logic [DATA_W-1:0]    data_arr [NUM_PORTS];
  logic                 accept;
  logic                 last_beat;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      len_arr[i]  = bus.req_len[i*LEN_W +: LEN_W];
      data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign owner_oh = NUM_PORTS'(1) << owner_q;
  assign bus.done = done_q;
  assign busy     = (state_q == XFER);

`ifdef ARB_BURST_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [NUM_PORTS-1:0] timeout_q, timeout_d;
  logic                 stall_hit;

  // The cycle that would bring the count to TIMEOUT_CYC is the abort cycle.
  assign stall_hit = (stall_q == STALL_W'(TIMEOUT_CYC - 1));
  assign timeout   = timeout_q;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    done_d        = '0;
    arb_request   = '0;
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_id    = '0;
    bus.out_last  = 1'b0;
    accept        = 1'b0;
    last_beat     = 1'b0;
`ifdef ARB_BURST_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        arb_request = rst ? '0 : bus.req_valid;
        // A grant to a client that is not requesting is dropped.
        if (arb_valid_grant && bus.req_valid[arb_grant_id]) begin
          state_d    = XFER;
          owner_d    = arb_grant_id;
          len_d      = len_arr[arb_grant_id];
          beat_cnt_d = '0;
`ifdef ARB_BURST_TIMEOUT_EN
          stall_d    = '0;
`endif
        end
      end
      XFER: begin
        arb_request   = owner_oh;
        last_beat     = (beat_cnt_q == len_q);
        bus.out_valid = bus.req_valid[owner_q];
        bus.out_data  = data_arr[owner_q];
        bus.out_id    = owner_q;
        bus.out_last  = last_beat;
        accept        = bus.req_valid[owner_q] && bus.out_ready;
        if (accept) begin
          bus.req_ready = owner_oh;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = owner_oh;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
`ifdef ARB_BURST_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_hit) begin
          state_d   = IDLE;
          timeout_d = owner_oh;
          stall_d   = '0;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
    end
  end

`ifdef ARB_BURST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= '0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_arb_burst_ctrl.sv
// Scoreboard bench for arb_burst_ctrl: random clients and arbiter, per-client expected-beat queues.
// Also covers reset state, grant latency, mid-burst reset and (with ARB_BURST_TIMEOUT_EN) the timeout.
module tb_arb_burst_ctrl;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int LW = 4;
`ifdef ARB_BURST_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic          clk;
  logic          rst;
  logic [NP-1:0] arb_request;
  logic [1:0]    arb_grant_id;
  logic          arb_valid_grant;
  logic          busy;
`ifdef ARB_BURST_TIMEOUT_EN
  logic [NP-1:0] timeout;
`endif

  arb_burst_ctrl_if #(.NUM_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) bus ();

  arb_burst_ctrl #(.NUM_PORTS(NP), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .arb_request     (arb_request),
    .arb_grant_id    (arb_grant_id),
    .arb_valid_grant (arb_valid_grant),
    .busy            (busy)
`ifdef ARB_BURST_TIMEOUT_EN
    ,
    .timeout         (timeout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit gen_en = 1'b0;

  logic [31:0] cl_buf [NP][16];
  int          cl_len [NP];
  int          cl_pos [NP];
  bit          cl_act [NP];
  logic [32:0] exp_q  [NP][$];
  int          rr = NP - 1;
  int          stall_run = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int i);
    oh = NP'(1) << i;
  endfunction

  function automatic bit any_active();
    any_active = 1'b0;
    for (int i = 0; i < NP; i++) if (cl_act[i]) any_active = 1'b1;
  endfunction

  // One random cycle: clients, sink and arbiter, then note accepted beats.
  task automatic drive_random();
    logic [NP-1:0] rq;
    int            pick;
    bit            force_go;
    force_go = (stall_run >= 3);
    for (int i = 0; i < NP; i++) begin
      if (cl_act[i] && cl_pos[i] > cl_len[i]) cl_act[i] = 1'b0;
      if (!cl_act[i] && gen_en && $urandom_range(0, 3) == 0) begin
        cl_len[i] = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
        for (int b = 0; b <= cl_len[i]; b++) begin
          cl_buf[i][b] = $urandom;
          exp_q[i].push_back({(b == cl_len[i]), cl_buf[i][b]});
        end
        cl_pos[i] = 0;
        cl_act[i] = 1'b1;
        bus.req_len[i*LW +: LW] = LW'(cl_len[i]);
      end else if (cl_act[i] && cl_pos[i] > 0) begin
        bus.req_len[i*LW +: LW] = LW'($urandom);
      end
      bus.req_valid[i] = cl_act[i] && (force_go || $urandom_range(0, 3) != 0);
      bus.req_data[i*DW +: DW] = cl_act[i] ? cl_buf[i][cl_pos[i]] : $urandom;
    end
    bus.out_ready = force_go || ($urandom_range(0, 9) < 7);
    #1;
    rq = arb_request;
    arb_valid_grant = 1'b0;
    arb_grant_id    = 2'($urandom);
    pick = rr;
    if ($urandom_range(0, 15) == 0) begin
      arb_valid_grant = 1'b1;
    end else if (rq != '0 && $urandom_range(0, 4) != 0) begin
      for (int k = 1; k <= NP; k++) begin
        pick = (rr + k) % NP;
        if (rq[pick]) break;
      end
      arb_valid_grant = 1'b1;
      arb_grant_id    = 2'(pick);
      rr = pick;
    end
    #1;
    if (busy && !(bus.out_valid && bus.out_ready)) stall_run++;
    else stall_run = 0;
    for (int i = 0; i < NP; i++) if (bus.req_ready[i]) cl_pos[i]++;
  endtask

  // Reference model: owner and beats remaining come from the grant and the captured length.
  bit            m_busy;
  int            m_owner;
  int            m_left;
  logic [NP-1:0] m_done;
  initial begin
    bit          nb;
    bit          ev;
    bit          hs;
    logic [NP-1:0] nd;
    logic [32:0] e;
    m_busy = 0; m_owner = 0; m_left = 0; m_done = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!mon_en) begin
        m_busy = 0; m_owner = 0; m_left = 0; m_done = '0;
      end else begin
        chk("busy", busy, m_busy);
        chk("done", bus.done, m_done);
`ifdef ARB_BURST_TIMEOUT_EN
        chk("timeout_quiet", timeout, 0);
`endif
        nb = m_busy;
        nd = '0;
        if (m_busy) begin
          chk("arb_request_xfer", arb_request, oh(m_owner));
          ev = bus.req_valid[m_owner];
          chk("out_valid", bus.out_valid, ev);
          hs = ev && bus.out_ready;
          chk("req_ready", bus.req_ready, hs ? oh(m_owner) : '0);
          if (hs) begin
            chk("out_id", bus.out_id, m_owner);
            if (exp_q[m_owner].size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_beat: client %0d data %0h with empty queue", m_owner, bus.out_data);
            end else begin
              e = exp_q[m_owner].pop_front();
              chk("out_data", bus.out_data, e[31:0]);
              chk("out_last", bus.out_last, e[32]);
            end
            m_left--;
            if (m_left == 0) begin
              nb = 0;
              nd = oh(m_owner);
            end
          end
        end else begin
          chk("arb_request_idle", arb_request, bus.req_valid);
          chk("out_valid_idle", bus.out_valid, 0);
          chk("req_ready_idle", bus.req_ready, 0);
          if (arb_valid_grant && bus.req_valid[arb_grant_id]) begin
            nb      = 1;
            m_owner = int'(arb_grant_id);
            m_left  = int'(bus.req_len[int'(arb_grant_id)*LW +: LW]) + 1;
          end
        end
        m_busy = nb;
        m_done = nd;
      end
    end
  end

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_len     = '0;
    bus.req_data    = '0;
    bus.out_ready   = 1'b0;
    arb_valid_grant = 1'b0;
    arb_grant_id    = '0;
  endtask

  // Directed single burst with out_ready held high; checks grant-to-beat latency and done timing.
  task automatic run_burst(input int id, input int len, input logic [31:0] base);
    @(negedge clk);
    bus.req_len[id*LW +: LW]  = LW'(len);
    bus.req_data[id*DW +: DW] = base;
    bus.req_valid             = oh(id);
    bus.out_ready             = 1'b1;
    arb_grant_id              = 2'(id);
    arb_valid_grant           = 1'b1;
    #3;
    chk("dir_grant_busy", busy, 0);
    chk("dir_grant_req", arb_request, oh(id));
    @(negedge clk);
    arb_valid_grant = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b > 0) begin
        @(negedge clk);
        bus.req_data[id*DW +: DW] = base + 32'(b);
      end
      #3;
      chk("dir_out_valid", bus.out_valid, 1);
      chk("dir_out_data", bus.out_data, base + 32'(b));
      chk("dir_out_id", bus.out_id, id);
      chk("dir_out_last", bus.out_last, (b == len));
      chk("dir_req_ready", bus.req_ready, oh(id));
      chk("dir_done_early", bus.done, 0);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #3;
    chk("dir_done", bus.done, oh(id));
    chk("dir_busy_after", busy, 0);
    chk("dir_out_valid_after", bus.out_valid, 0);
    @(negedge clk);
    #3;
    chk("dir_done_once", bus.done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < NP; i++) begin
      cl_act[i] = 1'b0; cl_pos[i] = 0; cl_len[i] = 0;
    end
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_arb_request", arb_request, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_id", bus.out_id, 0);
      chk("rst_out_last", bus.out_last, 0);
`ifdef ARB_BURST_TIMEOUT_EN
      chk("rst_timeout", timeout, 0);
`endif
    end

    run_burst(2, 3, 32'hA0);

    mon_en = 1'b1;
    gen_en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      drive_random();
    end
    gen_en = 1'b0;
    cyc = 0;
    while ((any_active() || busy) && cyc < 1000) begin
      @(negedge clk);
      drive_random();
      cyc++;
    end
    total++;
    if (cyc >= 1000) begin
      bad++;
      $display("FAIL drain: bursts still pending after %0d cycles, required 0 pending", cyc);
    end
    repeat (2) begin
      @(negedge clk);
      drive_random();
    end
    for (int i = 0; i < NP; i++) chk("exp_queue_empty", exp_q[i].size(), 0);
    @(negedge clk);
    mon_en = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);

    // Reset during beat 1 of a 4-beat burst.
    @(negedge clk);
    bus.req_len[3*LW +: LW]  = 4'd3;
    bus.req_data[3*DW +: DW] = 32'hC0;
    bus.req_valid            = oh(3);
    bus.out_ready            = 1'b1;
    arb_grant_id             = 2'd3;
    arb_valid_grant          = 1'b1;
    @(negedge clk);
    arb_valid_grant = 1'b0;
    #3;
    chk("mid_beat0", bus.out_data, 32'hC0);
    @(negedge clk);
    bus.req_data[3*DW +: DW] = 32'hC1;
    #2;
    chk("mid_beat1", bus.out_data, 32'hC1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_arb_request", arb_request, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_out_last", bus.out_last, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (2) begin
      @(negedge clk);
      #3;
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_burst(3, 3, 32'hD0);

`ifdef ARB_BURST_TIMEOUT_EN
    @(negedge clk);
    bus.req_len[0 +: LW] = 4'd3;
    bus.req_data[0 +: DW] = 32'hE0;
    bus.req_valid         = oh(0);
    bus.out_ready         = 1'b0;
    arb_grant_id          = 2'd0;
    arb_valid_grant       = 1'b1;
    for (int s = 0; s < TO_CYC; s++) begin
      @(negedge clk);
      arb_valid_grant = 1'b0;
      #3;
      chk("to_stall_busy", busy, 1);
      chk("to_stall_timeout", timeout, 0);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #3;
    chk("to_pulse", timeout, oh(0));
    chk("to_busy", busy, 0);
    chk("to_done", bus.done, 0);
    @(negedge clk);
    #3;
    chk("to_pulse_once", timeout, 0);
    chk("to_done_after", bus.done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
